hamming_dec_engine: RTL and testbench

Hardware SECDED decoder stage that sits directly downstream of the Hamming encoder (program 1) output.
- Reads the 15 16-bit codewords the encoder leaves in data memory at bytes 30..59.
- Corrects single-bit errors and flags double-bit errors.
- Writes the recovered 11-bit messages, with status flags, to bytes 0..29.
- Runs from a start/ack handshake and owns the data-memory port while busy.

---
 rtl/hamming_dec_engine.sv | 154 +++++++++++++++
 tb/tb_hamming_dec_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec_engine.sv
// SECDED decoder: reads 16-bit Hamming codewords from data memory,
// corrects single errors, flags double errors, writes messages back.
module hamming_dec_engine #(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wen,
  output logic [7:0]    mem_wdata,
  output logic [3:0]    sec_cnt,
  output logic [3:0]    ded_cnt
);

  localparam int IW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_MSGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [15:0]   cw_q, cw_d;
  logic [3:0]    sec_q, sec_d;
  logic [3:0]    ded_q, ded_d;

  logic [3:0]    syn;
  logic [3:0]    pos;
  logic          pe;
  logic          flip;
  logic [1:0]    flag;
  logic [10:0]   msg;

  logic [AW-1:0] src_lo;
  logic [AW-1:0] dst_lo;

  assign src_lo  = AW'(SRC_BASE) + AW'({i_q, 1'b0});
  assign dst_lo  = AW'(DST_BASE) + AW'({i_q, 1'b0});
  assign sec_cnt = sec_q;
  assign ded_cnt = ded_q;

  // Data bit j sits at Hamming position 3, 5..7, 9..15; flip it only
  // when the syndrome points at it and overall parity says single error.
  always_comb begin
    syn  = '0;
    pos  = '0;
    msg  = '0;
    flag = 2'b00;
    for (int k = 1; k < 16; k++) begin
      if (cw_q[k]) begin
        syn = syn ^ 4'(k);
      end
    end
    pe   = ^cw_q;
    flip = pe && (syn != 4'd0);
    for (int j = 0; j < 11; j++) begin
      pos    = 4'((j == 0) ? 3 : ((j < 4) ? j + 4 : j + 5));
      msg[j] = cw_q[pos] ^ (flip && (syn == pos));
    end
    if (pe) begin
      flag = 2'b01;
    end else if (syn != 4'd0) begin
      flag = 2'b10;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    cw_d      = cw_q;
    sec_d     = sec_q;
    ded_d     = ded_q;
    ack       = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE, DONE: begin
        ack = (state_q == DONE);
        if (start) begin
          state_d = RD_LO;
          i_d     = '0;
          sec_d   = '0;
          ded_d   = '0;
        end
      end
      RD_LO: begin
        mem_addr   = src_lo;
        cw_d[7:0]  = mem_rdata;
        state_d    = RD_HI;
      end
      RD_HI: begin
        mem_addr   = src_lo + AW'(1);
        cw_d[15:8] = mem_rdata;
        state_d    = WR_LO;
      end
      WR_LO: begin
        mem_wen   = 1'b1;
        mem_addr  = dst_lo;
        mem_wdata = msg[7:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_wen   = 1'b1;
        mem_addr  = dst_lo + AW'(1);
        mem_wdata = {flag, 3'b000, msg[10:8]};
        if (flag == 2'b01 && sec_q != 4'hF) begin
          sec_d = sec_q + 4'd1;
        end
        if (flag == 2'b10 && ded_q != 4'hF) begin
          ded_d = ded_q + 4'd1;
        end
        if (i_q == LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = RD_LO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      cw_q    <= '0;
      sec_q   <= '0;
      ded_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      cw_q    <= cw_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
    end
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench for hamming_dec_engine: directed codewords in,
// expected message bytes queued, monitor checks each memory write.
module tb_hamming_dec_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [3:0] sec_cnt;
  logic [3:0] ded_cnt;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  hamming_dec_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ack      (ack),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wen  (mem_wen),
    .mem_wdata(mem_wdata),
    .sec_cnt  (sec_cnt),
    .ded_cnt  (ded_cnt)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write", {mem_addr, mem_wdata}, {e.addr, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [15:0] cw,
                         input logic [7:0] lo, input logic [7:0] hi);
    mem[30 + 2*i] = cw[7:0];
    mem[31 + 2*i] = cw[15:8];
    exp_q.push_back({8'(2*i), lo});
    exp_q.push_back({8'(2*i + 1), hi});
  endtask

  task automatic set_all(input logic [15:0] cw, input logic [7:0] lo,
                         input logic [7:0] hi);
    for (int i = 0; i < 15; i++) set_vec(i, cw, lo, hi);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_ack", ack, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_sec", sec_cnt, 0);
    chk("rst_ded", ded_cnt, 0);

    // Run A: all clean 000F
    set_all(16'h000F, 8'h01, 8'h00);
    do_start();
    chk("a_ack_low", ack, 0);
    wait_ack(n);
    chk("a_latency", n, 60);
    chk("a_sec", sec_cnt, 0);
    chk("a_ded", ded_cnt, 0);
    chk("a_qempty", exp_q.size(), 0);

    // Run B: mixed directed vectors, restarted from DONE
    set_vec(0,  16'h000F, 8'h01, 8'h00);
    set_vec(1,  16'h100F, 8'h01, 8'h40);
    set_vec(2,  16'h102F, 8'h83, 8'h80);
    set_vec(3,  16'h000E, 8'h01, 8'h40);
    set_vec(4,  16'h0000, 8'h00, 8'h00);
    set_vec(5,  16'hFFFF, 8'hFF, 8'h07);
    set_vec(6,  16'hFF7F, 8'hFF, 8'h47);
    set_vec(7,  16'hFFF9, 8'hFF, 8'h87);
    set_vec(8,  16'h8117, 8'h00, 8'h04);
    set_vec(9,  16'h8317, 8'h00, 8'h44);
    set_vec(10, 16'h0303, 8'h10, 8'h00);
    set_vec(11, 16'h0302, 8'h10, 8'h40);
    set_vec(12, 16'h030A, 8'h11, 8'h80);
    set_vec(13, 16'hC303, 8'h10, 8'h86);
    set_vec(14, 16'h0033, 8'h02, 8'h00);
    do_start();
    chk("b_ack_drop", ack, 0);
    wait_ack(n);
    chk("b_latency", n, 60);
    chk("b_sec", sec_cnt, 5);
    chk("b_ded", ded_cnt, 4);
    repeat (3) step();
    chk("b_ack_hold", ack, 1);
    chk("b_sec_hold", sec_cnt, 5);
    chk("b_ded_hold", ded_cnt, 4);
    chk("b_qempty", exp_q.size(), 0);

    // Run C: extra start pulse mid-run is ignored
    set_all(16'h0303, 8'h10, 8'h00);
    do_start();
    repeat (9) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_ack(n);
    chk("c_latency", n, 50);
    chk("c_sec", sec_cnt, 0);
    chk("c_ded", ded_cnt, 0);
    chk("c_qempty", exp_q.size(), 0);

    // Run D: reset sampled at cycle k+20 aborts after 10 writes
    for (int a = 0; a < 30; a++) mem[a] = 8'hEE;
    set_all(16'h0033, 8'h02, 8'h00);
    do_start();
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("d_ack", ack, 0);
    chk("d_wen", mem_wen, 0);
    chk("d_addr", mem_addr, 0);
    chk("d_sec", sec_cnt, 0);
    chk("d_pending", exp_q.size(), 20);
    exp_q.delete();
    repeat (10) step();
    bad = 0;
    for (int a = 0; a < 30; a++) begin
      if (a < 10 && mem[a] !== ((a % 2 == 0) ? 8'h02 : 8'h00)) bad++;
      if (a >= 10 && mem[a] !== 8'hEE) bad++;
    end
    chk("d_mem_image", bad, 0);

    // Run E: fresh start after abort, every word has p0 flipped
    for (int a = 0; a < 30; a++) mem[a] = 8'hEE;
    set_all(16'h000E, 8'h01, 8'h40);
    do_start();
    wait_ack(n);
    chk("e_latency", n, 60);
    chk("e_sec", sec_cnt, 15);
    chk("e_ded", ded_cnt, 0);
    chk("e_qempty", exp_q.size(), 0);
    bad = 0;
    for (int a = 0; a < 30; a++) begin
      if (mem[a] !== ((a % 2 == 0) ? 8'h01 : 8'h40)) bad++;
    end
    chk("e_mem_image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
